// File: rtl/pcie_fifo_pkg.sv
// Shared helpers for the PCIe pack FIFO: clog2, pack-ratio derivation and lane-select widths.
package pcie_fifo_pkg;

    localparam int DEF_RATIO  = 8;
    localparam int DEF_LANE_W = 3;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic int calc_ratio(input int out_w, input int in_w);
        return out_w / in_w;
    endfunction

    // Lane counter needs at least one bit even for a degenerate 1:1 ratio.
    function automatic int lane_width(input int ratio);
        return (clog2(ratio) > 0) ? clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/pcie_pack_sdpram.sv
// Simple dual-port RAM, one write port and one registered read port that holds when not enabled.
module pcie_pack_sdpram #(
    parameter int W  = 128,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [0:(1<<AW)-1];
    logic [W-1:0] rdata_q;

    // Storage array write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register doubles as the visible output word, so it is reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= rdata_q;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pcie_pack_fifo.sv
// Width-upconverting pack FIFO for the PCIe DMA path; define PCIE_PACK_FIFO_FWFT_EN for
// first-word-fall-through reads (the RAM read register then acts as the prefetch register).
module pcie_pack_fifo
    import pcie_fifo_pkg::*;
#(
    parameter int IN_WIDTH         = 16,
    parameter int OUT_WIDTH        = 128,
    parameter int DEPTH_WIDTH      = 12,
    parameter int ALMOST_FULL_NUM  = 4064,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [IN_WIDTH-1:0]    wr_data,
    input  logic                   flush,
    output logic                   wr_full,
    output logic                   almost_full,
    output logic [DEPTH_WIDTH+clog2(OUT_WIDTH/IN_WIDTH):0] wr_water_level,
    input  logic                   rd_en,
    output logic [OUT_WIDTH-1:0]   rd_data,
    output logic                   rd_valid,
    output logic                   rd_empty,
    output logic                   almost_empty,
    output logic [DEPTH_WIDTH:0]   rd_water_level,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int RATIO      = calc_ratio(OUT_WIDTH, IN_WIDTH);
    localparam int LOG2_RATIO = clog2(RATIO);
    localparam int LANE_W     = lane_width(RATIO);
    localparam int CW         = DEPTH_WIDTH + 1;
    localparam int WLW        = DEPTH_WIDTH + LOG2_RATIO + 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
    localparam logic [CW-1:0]     DEPTH_C   = {1'b1, {DEPTH_WIDTH{1'b0}}};
    localparam logic [CW-1:0]     AF_C      = CW'(ALMOST_FULL_NUM);
    localparam logic [CW-1:0]     AE_C      = CW'(ALMOST_EMPTY_NUM);

    logic [LANE_W-1:0]      lane_q, lane_d;
    logic [OUT_WIDTH-1:0]   pack_q, pack_d, merged_s;
    logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic wr_acc_s, commit_s, pop_s, re_s;
    logic rd_valid_q, rd_valid_d, rd_empty_q, rd_empty_d;
    logic wr_full_q, almost_full_q, almost_empty_q, overflow_q, underflow_q;
`ifdef PCIE_PACK_FIFO_FWFT_EN
    logic [CW-1:0]          ram_cnt_s;
`endif

    // Write side: lane merge, commit of full or flushed words, write pointer
    always_comb begin
        wr_acc_s = wr_en & ~wr_full_q;
        merged_s = pack_q;
        if (wr_acc_s) begin
            merged_s[int'(lane_q)*IN_WIDTH +: IN_WIDTH] = wr_data;
        end else begin
            merged_s = pack_q;
        end
        // Upper lanes are already zero because the pack register is cleared on every commit.
        commit_s = (wr_acc_s & (lane_q == LAST_LANE))
                 | (flush & ~wr_full_q & ((lane_q != '0) | wr_en));
        if (commit_s) begin
            lane_d   = '0;
            pack_d   = '0;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else if (wr_acc_s) begin
            lane_d   = lane_q + 1'b1;
            pack_d   = merged_s;
            wr_ptr_d = wr_ptr_q;
        end else begin
            lane_d   = lane_q;
            pack_d   = pack_q;
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Read side: pop, RAM read enable and next-cycle valid/empty
    always_comb begin
`ifdef PCIE_PACK_FIFO_FWFT_EN
        pop_s      = rd_en & rd_valid_q;
        ram_cnt_s  = count_q - {{DEPTH_WIDTH{1'b0}}, rd_valid_q};
        re_s       = (ram_cnt_s != '0) & (~rd_valid_q | pop_s);
        rd_valid_d = re_s | (rd_valid_q & ~pop_s);
`else
        pop_s      = rd_en & ~rd_empty_q;
        re_s       = pop_s;
        rd_valid_d = pop_s;
`endif
        if (re_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (commit_s && !pop_s) begin
            count_d = count_q + 1'b1;
        end else if (!commit_s && pop_s) begin
            count_d = count_q - 1'b1;
        end else begin
            count_d = count_q;
        end
`ifdef PCIE_PACK_FIFO_FWFT_EN
        rd_empty_d = ~rd_valid_d;
`else
        rd_empty_d = (count_d == '0);
`endif
    end

    // State and status registers; flags are registered from next-state count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q         <= '0;
            pack_q         <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            rd_valid_q     <= 1'b0;
            rd_empty_q     <= 1'b1;
            wr_full_q      <= 1'b0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            lane_q         <= lane_d;
            pack_q         <= pack_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            rd_valid_q     <= rd_valid_d;
            rd_empty_q     <= rd_empty_d;
            wr_full_q      <= (count_d == DEPTH_C);
            almost_full_q  <= (count_d >= AF_C);
            almost_empty_q <= (count_d <= AE_C);
            overflow_q     <= overflow_q | (wr_en & wr_full_q);
            underflow_q    <= underflow_q | (rd_en & rd_empty_q);
        end
    end

    pcie_pack_sdpram #(
        .W  (OUT_WIDTH),
        .AW (DEPTH_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (commit_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (merged_s),
        .re_i    (re_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    assign wr_full        = wr_full_q;
    assign almost_full    = almost_full_q;
    assign wr_water_level = (WLW'(count_q) << LOG2_RATIO) + WLW'(lane_q);
    assign rd_valid       = rd_valid_q;
    assign rd_empty       = rd_empty_q;
    assign almost_empty   = almost_empty_q;
    assign rd_water_level = count_q;
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;

endmodule

// File: tb/tb_pcie_pack_fifo.sv
// Scoreboard bench for pcie_pack_fifo (default standard-read build) against a queue-based model.
module tb_pcie_pack_fifo;

    localparam int DEPTH = 4096;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_en = 1'b0;
    logic [15:0]  wr_data = 16'h0000;
    logic         flush = 1'b0;
    logic         rd_en = 1'b0;
    logic         wr_full, almost_full, rd_valid, rd_empty, almost_empty, overflow, underflow;
    logic [15:0]  wr_water_level;
    logic [127:0] rd_data;
    logic [12:0]  rd_water_level;

    int total = 0;
    int bad   = 0;

    logic [127:0] exp_q[$];
    logic [127:0] m_store[$];
    logic [15:0]  m_lanes[$];
    logic [127:0] m_last = 128'h0;
    bit           m_ovf = 1'b0;
    bit           m_unf = 1'b0;
    bit           m_valid = 1'b0;

    always #5 clk = ~clk;

    pcie_pack_fifo dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .flush          (flush),
        .wr_full        (wr_full),
        .almost_full    (almost_full),
        .wr_water_level (wr_water_level),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_empty       (rd_empty),
        .almost_empty   (almost_empty),
        .rd_water_level (rd_water_level),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Little-endian concatenation of the collected lanes, unused lanes zero.
    function automatic logic [127:0] pack_word();
        logic [127:0] w;
        w = 128'h0;
        foreach (m_lanes[i]) w[i*16 +: 16] = m_lanes[i];
        return w;
    endfunction

    task automatic check_status();
        int c;
        c = m_store.size();
        chk("rd_empty",       rd_empty,       c == 0);
        chk("almost_empty",   almost_empty,   c <= 4);
        chk("wr_full",        wr_full,        c == DEPTH);
        chk("almost_full",    almost_full,    c >= 4064);
        chk("rd_water_level", rd_water_level, c);
        chk("wr_water_level", wr_water_level, c * 8 + m_lanes.size());
        chk("overflow",       overflow,       m_ovf);
        chk("underflow",      underflow,      m_unf);
        chk("rd_valid",       rd_valid,       m_valid);
        chk("rd_data",        rd_data,        m_last);
    endtask

    task automatic step(input bit we, input logic [15:0] wd, input bit fl, input bit re);
        int c;
        bit full, acc, flok, pop;
        logic [127:0] w;
        @(negedge clk);
        check_status();
        wr_en = we; wr_data = wd; flush = fl; rd_en = re;
        c    = m_store.size();
        full = (c == DEPTH);
        acc  = we && !full;
        flok = fl && !full && (m_lanes.size() > 0 || we);
        pop  = re && (c > 0);
        if (we && full) m_ovf = 1'b1;
        if (re && c == 0) m_unf = 1'b1;
        @(posedge clk);
        if (pop) begin
            w = m_store.pop_front();
            exp_q.push_back(w);
            m_last = w;
        end
        m_valid = pop;
        if (acc) m_lanes.push_back(wd);
        if (m_lanes.size() == 8 || flok) begin
            m_store.push_back(pack_word());
            m_lanes.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; wr_en = 1'b0; flush = 1'b0; rd_en = 1'b0; wr_data = 16'h0000;
        @(posedge clk);
        #1;
        m_store.delete(); m_lanes.delete(); exp_q.delete();
        m_last = 128'h0; m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_status();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    // Monitor: every presented word must match the oldest expected pop.
    always @(negedge clk) begin
        logic [127:0] w;
        if (rst_n === 1'b1 && rd_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got %0h, want no word", rd_data);
            end else begin
                w = exp_q.pop_front();
                if (rd_data !== w) begin
                    bad++;
                    $display("FAIL sb_word: got %0h, want %0h", rd_data, w);
                end
            end
        end
    end

    initial begin
        do_reset();

        for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        idle(1);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        idle(2);

        step(1'b1, 16'hA1A1, 1'b0, 1'b0);
        step(1'b1, 16'hB2B2, 1'b0, 1'b0);
        step(1'b1, 16'hC3C3, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        idle(2);

        do_reset();
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        idle(2);

        do_reset();
        for (int i = 0; i < 47; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        step(1'b1, 16'($urandom), 1'b0, 1'b1);
        idle(1);
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0000, 1'b0, 1'b1);
        idle(2);

        do_reset();
        for (int i = 0; i < 85; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h7000 + i), 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, 16'($urandom), ($urandom % 16) == 0,
                 (i < 1500) ? (($urandom % 8) == 0) : (($urandom % 2) == 0));
        end
        for (int i = 0; i < 600; i++) step(1'b0, 16'h0000, 1'b0, 1'b1);
        idle(2);

        do_reset();
        for (int i = 0; i < 8 * DEPTH; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
        step(1'b1, 16'hDEAD, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b1);
        idle(3);

        chk("sb_drained", 128'(exp_q.size()), 128'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
